// File: rtl/kyber_pkg.sv
// Shared Kyber arithmetic constants, coefficient type and Barrett helper.
package kyber_pkg;

  localparam int Q         = 3329;
  localparam int QINV      = 62209;
  localparam int BARRETT_V = 20159;

  typedef logic signed [15:0] coeff_t;

  // Centred Barrett reduction: result congruent to x mod Q, roughly in (-Q/2, Q/2].
  function automatic coeff_t barrett_reduce(coeff_t x);
    int xs;
    int k;
    xs = int'(x);
    k  = (BARRETT_V * xs + (1 << 25)) >>> 26;
    return coeff_t'(xs - k * Q);
  endfunction

endpackage

// File: rtl/mont_reduce.sv
// Combinational Montgomery reduction: r = (x - u*Q) / 2^16 with u = int16(x * QINV).
module mont_reduce
  import kyber_pkg::*;
(
  input  logic signed [31:0] x,
  output coeff_t             r
);

  localparam logic [15:0] QINV_L = 16'(QINV);

  logic signed [15:0] u;
  logic signed [31:0] uq;
  logic signed [31:0] diff;

  always_comb begin
    // Only the low 16 bits of x*QINV matter, so multiply in 16-bit width.
    u    = x[15:0] * QINV_L;
    uq   = int'(u) * Q;
    diff = x - uq;
    r    = coeff_t'(diff >>> 16);
  end

endmodule

// File: rtl/ntt_butterfly.sv
// Three-stage Cooley-Tukey NTT butterfly with a global stall enable.
// Define NTT_BUTTERFLY_BARRETT_EN to Barrett-reduce both outputs before the final register.
module ntt_butterfly
  import kyber_pkg::*;
#(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      a_in,
  input  logic [15:0]      b_in,
  input  logic [15:0]      zeta,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      a_out,
  output logic [15:0]      b_out,
  output logic [TAG_W-1:0] tag_out
);

  logic              adv;

  logic              s1_valid_reg;
  logic signed [31:0] s1_prod_reg;
  coeff_t            s1_a_reg;
  logic [TAG_W-1:0]  s1_tag_reg;

  logic              s2_valid_reg;
  coeff_t            s2_t_reg;
  coeff_t            s2_a_reg;
  logic [TAG_W-1:0]  s2_tag_reg;

  coeff_t            t_next;
  coeff_t            sum_next;
  coeff_t            dif_next;
  coeff_t            a_res_next;
  coeff_t            b_res_next;

  // One enable moves every stage, bubbles included, so latency stays fixed.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  mont_reduce u_mont (
    .x (s1_prod_reg),
    .r (t_next)
  );

  always_comb begin
    sum_next = s2_a_reg + s2_t_reg;
    dif_next = s2_a_reg - s2_t_reg;
`ifdef NTT_BUTTERFLY_BARRETT_EN
    a_res_next = barrett_reduce(sum_next);
    b_res_next = barrett_reduce(dif_next);
`else
    a_res_next = sum_next;
    b_res_next = dif_next;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_prod_reg  <= '0;
      s1_a_reg     <= '0;
      s1_tag_reg   <= '0;
      s2_valid_reg <= 1'b0;
      s2_t_reg     <= '0;
      s2_a_reg     <= '0;
      s2_tag_reg   <= '0;
      out_valid    <= 1'b0;
      a_out        <= '0;
      b_out        <= '0;
      tag_out      <= '0;
    end else if (adv) begin
      s1_valid_reg <= in_valid;
      s1_prod_reg  <= $signed(zeta) * $signed(b_in);
      s1_a_reg     <= coeff_t'(a_in);
      s1_tag_reg   <= tag_in;
      s2_valid_reg <= s1_valid_reg;
      s2_t_reg     <= t_next;
      s2_a_reg     <= s1_a_reg;
      s2_tag_reg   <= s1_tag_reg;
      out_valid    <= s2_valid_reg;
      a_out        <= a_res_next;
      b_out        <= b_res_next;
      tag_out      <= s2_tag_reg;
    end
  end

endmodule

// File: doc/ntt_butterfly.md
NTT_BUTTERFLY -- requirements
Module: ntt_butterfly

Interface
REQ-001 SHALL have parameter TAG_W, default 8, width of the sideband tag (coefficient index) carried alongside each butterfly.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operand set on a_in/b_in/zeta/tag_in is valid.
REQ-005 SHALL have port in_ready  output  1  block accepts the operand set this cycle.
REQ-006 SHALL have port a_in  input  16  signed coefficient a[j].
REQ-007 SHALL have port b_in  input  16  signed coefficient a[j+len].
REQ-008 SHALL have port zeta  input  16  signed twiddle factor, Montgomery form.
REQ-009 SHALL have port tag_in  input  TAG_W  opaque tag.
REQ-010 SHALL have port out_valid  output  1  result set on a_out/b_out/tag_out is valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result this cycle.
REQ-012 SHALL have ports a_out and b_out  output  16 each  signed results a+t and a-t.
REQ-013 SHALL have port tag_out  output  TAG_W  tag_in of the same operand set.

Function
REQ-014 SHALL implement the forward Cooley-Tukey butterfly: t = montgomery(zeta*b_in); a_out = a_in + t; b_out = a_in - t; 16-bit two's-complement wrap, no saturation.
REQ-015 SHALL compute montgomery(x) as u = low 16 bits of x*62209, interpreted as signed; r = (x - u*3329) >>> 16 (arithmetic).
REQ-016 SHALL be a 3-stage pipeline: S1 registers the 32-bit signed product zeta*b_in with a_in, tag and valid; S2 registers t with a, tag and valid; S3 registers a_out, b_out, tag_out and out_valid.
REQ-017 SHALL have a fixed latency of 3 cycles from the accept edge to out_valid when there is no stall.
REQ-018 SHALL accept an operand set when in_valid and in_ready are both high at the rising edge.
REQ-019 SHALL drive in_ready = !out_valid || out_ready (combinational); this is also the global pipeline-advance enable.
REQ-020 SHALL freeze all three stages, valid bits included, while the enable is low; out_valid and the output data hold stable until accepted.
REQ-021 SHALL advance bubbles, not collapse them: an invalid stage still shifts when the enable is high.
REQ-022 SHALL sustain throughput of 1 butterfly/cycle while out_ready stays high.
REQ-023 SHALL keep tag_out bit-exact with the tag_in of the same set; no reordering.

Reset
REQ-024 SHALL, on rst high and asynchronously, clear all valid bits and all data/tag registers to 0, so out_valid=0, a_out=b_out=0, tag_out=0, and in_ready=1.
REQ-025 SHALL discard in-flight operations when reset is asserted mid-operation; none emerge after rst is released.
REQ-026 SHALL accept an operand set on the first rising edge after rst deasserts.

Configuration
REQ-027 SHALL, with macro NTT_BUTTERFLY_BARRETT_EN defined, apply Barrett reduction to both S3 results before registering: v=20159; k=(v*x + 2^25) >>> 26; r = x - k*3329. Latency is unchanged.
REQ-028 SHALL, without NTT_BUTTERFLY_BARRETT_EN, register the unreduced a+t and a-t.

Structure
REQ-029 SHALL take constants Q=3329, QINV=62209 and BARRETT_V=20159 from the shared kyber package, along with the 16-bit signed coefficient typedef.
REQ-030 SHALL instantiate montgomery reduction as a combinational sub-module, mont_reduce, between S1 and S2.

Verification
REQ-031 Bench SHALL cover: a_in=100, b_in=0, zeta=2285 -> after 3 cycles a_out=100, b_out=100.
REQ-032 Bench SHALL cover: a_in=100, b_in=5, zeta=2285 -> a_out ≡ 105 and b_out ≡ 95 (mod 3329); exactly 105 and 95 with BARRETT_EN.
REQ-033 Bench SHALL cover, with BARRETT_EN: a_in=3000, b_in=0, zeta=2285 -> a_out=-329, b_out=-329; without the macro both are 3000.
REQ-034 Bench SHALL cover: 10 back-to-back sets, tags 0..9, with out_ready low on cycles 5-7 -> in_ready low exactly while out_valid is high and out_ready is low; outputs hold; all 10 emerge in tag order, none lost or duplicated.
REQ-035 Bench SHALL cover: rst pulsed with 2 sets in flight -> out_valid=0 immediately; no output for those tags afterwards; a new set is accepted on the first edge after release.
REQ-036 Bench SHALL cover: 10k random sets with |a|,|b|,|zeta| < 3329 -> outputs match a C model of the Kyber reference butterfly bit-exactly.
